// File: rtl/rtc_pkg.sv
// Shared widths, limits and helpers for the real-time-clock timekeeper.
package rtc_pkg;

    localparam int SEC_W    = 6;
    localparam int MIN_W    = 6;
    localparam int HOUR_W   = 5;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    typedef struct packed {
        logic [HOUR_W-1:0] hh;
        logic [MIN_W-1:0]  mm;
        logic [SEC_W-1:0]  ss;
    } rtc_time_t;

    // Returns {pm, display hour}; midnight and noon both show as 12.
    function automatic logic [HOUR_W:0] to_12h(input logic [HOUR_W-1:0] hh);
        logic              is_pm;
        logic [HOUR_W-1:0] disp;
        is_pm = (hh >= HOUR_W'(12));
        if (hh == '0) begin
            disp = HOUR_W'(12);
        end else if (hh > HOUR_W'(12)) begin
            disp = hh - HOUR_W'(12);
        end else begin
            disp = hh;
        end
        return {is_pm, disp};
    endfunction

endpackage

// File: rtl/rtc_wrap_counter.sv
// Modulo-(MAX+1) counter whose wrap output is combinational so carries ripple within one cycle.
module rtc_wrap_counter
    import rtc_pkg::*;
#(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = inc & (count == W'(MAX));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// Time-of-day core: prescaler, cascaded sec/min/hour counters, set mode, 12/24 h display,
// day rollover pulse and sticky hh:mm alarm.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int TICK_W        = $clog2(TICKS_PER_SEC)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              set_en,
    input  logic              inc_sec,
    input  logic              inc_min,
    input  logic              inc_hour,
    input  logic              mode_12h,
    input  logic              alarm_en,
    input  logic [HOUR_W-1:0] alarm_hh,
    input  logic [MIN_W-1:0]  alarm_mm,
    input  logic              alarm_clr,
    output logic [TICK_W-1:0] tick,
    output logic [SEC_W-1:0]  seconds,
    output logic [MIN_W-1:0]  minutes,
    output logic [HOUR_W-1:0] hours,
    output logic [HOUR_W-1:0] hour_disp,
    output logic              pm,
    output logic              day_pulse,
    output logic              alarm
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);

    logic            sec_step;
    logic            prev_sec, prev_min, prev_hour;
    logic            sec_edge, min_edge, hour_edge;
    logic            sec_inc, min_inc, hour_inc;
    logic            sec_wrap, min_wrap, hour_wrap;
    logic            alarm_hit;
    logic [HOUR_W:0] h12;
    rtc_time_t       next_time;

    assign sec_step = ~set_en & (tick == TICK_LAST);

    // Prescaler is held at zero in set mode so the first second after exit is a full one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick <= '0;
        end else if (set_en || sec_step) begin
            tick <= '0;
        end else begin
            tick <= tick + TICK_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_sec  <= 1'b0;
            prev_min  <= 1'b0;
            prev_hour <= 1'b0;
        end else begin
            prev_sec  <= inc_sec;
            prev_min  <= inc_min;
            prev_hour <= inc_hour;
        end
    end

    assign sec_edge  = inc_sec  & ~prev_sec;
    assign min_edge  = inc_min  & ~prev_min;
    assign hour_edge = inc_hour & ~prev_hour;

    // Set mode edits one field at a time with no carry; run mode chains the wraps.
    assign sec_inc  = set_en ? sec_edge  : sec_step;
    assign min_inc  = set_en ? min_edge  : sec_wrap;
    assign hour_inc = set_en ? hour_edge : min_wrap;

    rtc_wrap_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clock (clock),
        .reset (reset),
        .inc   (sec_inc),
        .count (seconds),
        .wrap  (sec_wrap)
    );

    rtc_wrap_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
        .clock (clock),
        .reset (reset),
        .inc   (min_inc),
        .count (minutes),
        .wrap  (min_wrap)
    );

    rtc_wrap_counter #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clock (clock),
        .reset (reset),
        .inc   (hour_inc),
        .count (hours),
        .wrap  (hour_wrap)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            day_pulse <= 1'b0;
        end else begin
            day_pulse <= ~set_en & hour_wrap;
        end
    end

    // Time the chain will hold after this run-mode step; only meaningful when sec_step is high.
    always_comb begin
        next_time.ss = sec_wrap ? '0 : seconds + SEC_W'(1);
        next_time.mm = min_wrap ? '0 : (sec_wrap ? minutes + MIN_W'(1) : minutes);
        next_time.hh = hour_wrap ? '0 : (min_wrap ? hours + HOUR_W'(1) : hours);
    end

    assign alarm_hit = sec_step & alarm_en
                     & (next_time.hh == alarm_hh)
                     & (next_time.mm == alarm_mm)
                     & (next_time.ss == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alarm <= 1'b0;
        end else if (alarm_hit) begin
            alarm <= 1'b1;
        end else if (alarm_clr) begin
            alarm <= 1'b0;
        end
    end

    always_comb begin
        h12       = to_12h(hours);
        pm        = h12[HOUR_W];
        hour_disp = mode_12h ? h12[HOUR_W-1:0] : hours;
    end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Directed self-checking bench for rtc_timekeeper with a 4-cycle second.
module tb_rtc_timekeeper;

    localparam int TPS = 4;
    localparam int TW  = $clog2(TPS);

    logic          clock = 1'b0;
    logic          reset;
    logic          set_en, inc_sec, inc_min, inc_hour;
    logic          mode_12h, alarm_en, alarm_clr;
    logic [4:0]    alarm_hh;
    logic [5:0]    alarm_mm;
    logic [TW-1:0] tick;
    logic [5:0]    seconds, minutes;
    logic [4:0]    hours, hour_disp;
    logic          pm, day_pulse, alarm;

    int n_checks = 0;
    int n_fail   = 0;

    rtc_timekeeper #(.TICKS_PER_SEC(TPS)) dut (
        .clock     (clock),
        .reset     (reset),
        .set_en    (set_en),
        .inc_sec   (inc_sec),
        .inc_min   (inc_min),
        .inc_hour  (inc_hour),
        .mode_12h  (mode_12h),
        .alarm_en  (alarm_en),
        .alarm_hh  (alarm_hh),
        .alarm_mm  (alarm_mm),
        .alarm_clr (alarm_clr),
        .tick      (tick),
        .seconds   (seconds),
        .minutes   (minutes),
        .hours     (hours),
        .hour_disp (hour_disp),
        .pm        (pm),
        .day_pulse (day_pulse),
        .alarm     (alarm)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkTime(input string tag, input int hh, input int mm, input int ss);
        checkOutput({tag, "_hh"}, 32'(hours), 32'(hh));
        checkOutput({tag, "_mm"}, 32'(minutes), 32'(mm));
        checkOutput({tag, "_ss"}, 32'(seconds), 32'(ss));
    endtask

    // Rising edges on one inc_* input: 0 = seconds, 1 = minutes, 2 = hours.
    task automatic applyStimulus(input int field, input int count);
        for (int i = 0; i < count; i++) begin
            inc_sec  = (field == 0);
            inc_min  = (field == 1);
            inc_hour = (field == 2);
            @(negedge clock);
            inc_sec  = 1'b0;
            inc_min  = 1'b0;
            inc_hour = 1'b0;
            @(negedge clock);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        set_en    = 1'b0;
        inc_sec   = 1'b0;
        inc_min   = 1'b0;
        inc_hour  = 1'b0;
        mode_12h  = 1'b0;
        alarm_en  = 1'b0;
        alarm_clr = 1'b0;
        alarm_hh  = 5'd0;
        alarm_mm  = 6'd0;
        repeat (2) @(negedge clock);

        $display("[TB] reset state and free-running seconds");
        checkOutput("rst_tick", 32'(tick), 0);
        checkTime("rst", 0, 0, 0);
        checkOutput("rst_hour_disp", 32'(hour_disp), 0);
        checkOutput("rst_pm", 32'(pm), 0);
        checkOutput("rst_day_pulse", 32'(day_pulse), 0);
        checkOutput("rst_alarm", 32'(alarm), 0);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            checkOutput("run_tick", 32'(tick), 32'(k % TPS));
            checkOutput("run_sec", 32'(seconds), 32'(k / TPS));
        end

        $display("[TB] day rollover from 23:59:58");
        set_en = 1'b1;
        @(negedge clock);
        applyStimulus(2, 23);
        applyStimulus(1, 59);
        applyStimulus(0, 56);
        checkTime("preset", 23, 59, 58);
        checkOutput("preset_tick", 32'(tick), 0);
        set_en = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            checkOutput("day_pulse", 32'(day_pulse), 32'(k == 8));
            if (k == 4) checkTime("roll_59", 23, 59, 59);
            if (k == 8) checkTime("roll_00", 0, 0, 0);
        end

        $display("[TB] set-mode minutes without carry");
        checkOutput("pre_set_tick", 32'(tick), 1);
        set_en = 1'b1;
        @(negedge clock);
        checkOutput("set_tick_zero", 32'(tick), 0);
        applyStimulus(1, 61);
        checkTime("min61", 0, 1, 0);
        checkOutput("min61_tick", 32'(tick), 0);

        $display("[TB] simultaneous set-mode edges");
        applyStimulus(1, 59);
        applyStimulus(2, 23);
        applyStimulus(0, 59);
        checkTime("pre_dual", 23, 0, 59);
        checkOutput("disp24_23", 32'(hour_disp), 23);
        checkOutput("pm_23", 32'(pm), 1);
        inc_sec  = 1'b1;
        inc_hour = 1'b1;
        @(negedge clock);
        checkTime("dual", 0, 0, 0);
        checkOutput("dual_day_pulse", 32'(day_pulse), 0);
        inc_sec  = 1'b0;
        inc_hour = 1'b0;
        @(negedge clock);
        checkOutput("dual_day_pulse_next", 32'(day_pulse), 0);

        $display("[TB] alarm at 07:30");
        alarm_hh = 5'd7;
        alarm_mm = 6'd30;
        alarm_en = 1'b1;
        applyStimulus(2, 7);
        applyStimulus(1, 30);
        checkTime("edit_0730", 7, 30, 0);
        checkOutput("edit_no_alarm", 32'(alarm), 0);
        applyStimulus(1, 59);
        applyStimulus(0, 59);
        checkTime("pre_alarm", 7, 29, 59);
        set_en = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("alarm_before", 32'(alarm), 0);
        alarm_clr = 1'b1;
        @(negedge clock);
        checkTime("alarm_time", 7, 30, 0);
        checkOutput("alarm_set_wins", 32'(alarm), 1);
        @(negedge clock);
        checkOutput("alarm_cleared", 32'(alarm), 0);
        alarm_clr = 1'b0;

        $display("[TB] 12 h display mapping");
        set_en   = 1'b1;
        mode_12h = 1'b1;
        @(negedge clock);
        applyStimulus(2, 17);
        checkOutput("h00_disp", 32'(hour_disp), 12);
        checkOutput("h00_pm", 32'(pm), 0);
        applyStimulus(2, 12);
        checkOutput("h12_disp", 32'(hour_disp), 12);
        checkOutput("h12_pm", 32'(pm), 1);
        applyStimulus(2, 1);
        checkOutput("h13_disp", 32'(hour_disp), 1);
        checkOutput("h13_pm", 32'(pm), 1);
        applyStimulus(2, 10);
        checkOutput("h23_disp", 32'(hour_disp), 11);
        mode_12h = 1'b0;
        #1;
        checkOutput("h23_disp24", 32'(hour_disp), 23);

        $display("[TB] asynchronous reset mid-second");
        set_en = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("mid_tick", 32'(tick), 2);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_tick", 32'(tick), 0);
        checkTime("async", 0, 0, 0);
        checkOutput("async_disp", 32'(hour_disp), 0);
        checkOutput("async_pm", 32'(pm), 0);
        checkOutput("async_alarm", 32'(alarm), 0);
        checkOutput("async_day_pulse", 32'(day_pulse), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("post_rst_tick", 32'(tick), 1);
        checkTime("post_rst", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
